// File: rtl/decomp_ingress_arb.sv
// Two-port packet-granular AXI-Stream arbiter feeding the decompression frontend.
// Optional per-port packet counters are enabled by defining ARB_PKT_CNT_EN.
module decomp_ingress_arb #(
    parameter int HOLD_MAX = 1
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [255:0] s0_axis_tdata,
    input  logic [31:0]  s0_axis_tkeep,
    input  logic         s0_axis_tvalid,
    input  logic         s0_axis_tlast,
    output logic         s0_axis_tready,
    input  logic [255:0] s1_axis_tdata,
    input  logic [31:0]  s1_axis_tkeep,
    input  logic         s1_axis_tvalid,
    input  logic         s1_axis_tlast,
    output logic         s1_axis_tready,
    output logic [255:0] m_axis_tdata,
    output logic [31:0]  m_axis_tkeep,
    output logic         m_axis_tvalid,
    output logic         m_axis_tlast,
    input  logic         m_axis_tready,
    output logic [1:0]   grant,
    output logic         busy
`ifdef ARB_PKT_CNT_EN
    ,
    output logic [31:0]  pkt_cnt0,
    output logic [31:0]  pkt_cnt1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_MAX_C = 4'(HOLD_MAX);
    localparam logic [3:0] HOLD_SAT_C = 4'd15;

    state_t     state_r;
    logic       last_r;
    logic [3:0] hold_cnt_r;
    logic       req_s;
    logic       pick_s;
    logic       end0_s;
    logic       end1_s;

    // Arbitration decision evaluated while idle; pick_s is the port to grant.
    always_comb begin
        req_s  = 1'b0;
        pick_s = last_r;
        if (s0_axis_tvalid && s1_axis_tvalid) begin
            req_s = 1'b1;
            if (hold_cnt_r < HOLD_MAX_C) begin
                pick_s = last_r;
            end else begin
                pick_s = ~last_r;
            end
        end else if (s0_axis_tvalid) begin
            req_s  = 1'b1;
            pick_s = 1'b0;
        end else if (s1_axis_tvalid) begin
            req_s  = 1'b1;
            pick_s = 1'b1;
        end else begin
            req_s  = 1'b0;
            pick_s = last_r;
        end
    end

    // Zero-latency forwarding path steered by the current owner.
    always_comb begin
        m_axis_tdata   = 256'd0;
        m_axis_tkeep   = 32'd0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state_r)
            ST_BUSY0: begin
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tkeep   = s0_axis_tkeep;
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tlast   = s0_axis_tlast;
                s0_axis_tready = m_axis_tready;
            end
            ST_BUSY1: begin
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tkeep   = s1_axis_tkeep;
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tlast   = s1_axis_tlast;
                s1_axis_tready = m_axis_tready;
            end
            default: begin
                m_axis_tvalid  = 1'b0;
                s0_axis_tready = 1'b0;
                s1_axis_tready = 1'b0;
            end
        endcase
    end

    // A packet ends only on a completed handshake of its tlast beat.
    always_comb begin
        end0_s = s0_axis_tvalid & s0_axis_tready & s0_axis_tlast;
        end1_s = s1_axis_tvalid & s1_axis_tready & s1_axis_tlast;
    end

    // Ownership FSM with registered status and fairness bookkeeping.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r    <= ST_IDLE;
            grant      <= 2'b00;
            busy       <= 1'b0;
            last_r     <= 1'b1;
            hold_cnt_r <= HOLD_MAX_C;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        state_r <= pick_s ? ST_BUSY1 : ST_BUSY0;
                        grant   <= pick_s ? 2'b10 : 2'b01;
                        busy    <= 1'b1;
                        last_r  <= pick_s;
                        if (pick_s == last_r) begin
                            hold_cnt_r <= (hold_cnt_r == HOLD_SAT_C) ? HOLD_SAT_C
                                                                     : hold_cnt_r + 4'd1;
                        end else begin
                            hold_cnt_r <= 4'd1;
                        end
                    end
                end
                ST_BUSY0: begin
                    if (end0_s) begin
                        state_r <= ST_IDLE;
                        grant   <= 2'b00;
                        busy    <= 1'b0;
                    end
                end
                ST_BUSY1: begin
                    if (end1_s) begin
                        state_r <= ST_IDLE;
                        grant   <= 2'b00;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant   <= 2'b00;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_PKT_CNT_EN
    logic [31:0] pkt_cnt0_r;
    logic [31:0] pkt_cnt1_r;

    // Completed-packet counters; wrap naturally at 2^32.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pkt_cnt0_r <= 32'd0;
            pkt_cnt1_r <= 32'd0;
        end else begin
            if (end0_s) begin
                pkt_cnt0_r <= pkt_cnt0_r + 32'd1;
            end
            if (end1_s) begin
                pkt_cnt1_r <= pkt_cnt1_r + 32'd1;
            end
        end
    end

    assign pkt_cnt0 = pkt_cnt0_r;
    assign pkt_cnt1 = pkt_cnt1_r;
`endif

endmodule

// File: tb/tb_decomp_ingress_arb.sv
// Scoreboard bench for decomp_ingress_arb: per-port expected-beat queues plus
// an expected grant-order queue; a second instance covers HOLD_MAX=2.
module tb_decomp_ingress_arb;

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
    } beat_t;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [255:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
    logic [31:0]  s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
    logic         s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
    logic         s0_axis_tlast, s1_axis_tlast, m_axis_tlast;
    logic         s0_axis_tready, s1_axis_tready, m_axis_tready;
    logic [1:0]   grant;
    logic         busy;
    logic         h2_valid;
    logic [255:0] h2_tdata;
    logic [31:0]  h2_tkeep;
    logic         h2_tvalid, h2_tlast, h2_s0_tready, h2_s1_tready;
    logic [1:0]   h2_grant;
    logic         h2_busy;
`ifdef ARB_PKT_CNT_EN
    logic [31:0]  pkt_cnt0, pkt_cnt1, h2_cnt0, h2_cnt1;
`endif

    always #5 aclk = ~aclk;

    decomp_ingress_arb #(.HOLD_MAX(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast),
        .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast),
        .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .grant(grant), .busy(busy)
`ifdef ARB_PKT_CNT_EN
        , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
    );

    decomp_ingress_arb #(.HOLD_MAX(2)) dut_h2 (
        .aclk(aclk), .aresetn(aresetn),
        .s0_axis_tdata(256'd0), .s0_axis_tkeep(32'd0),
        .s0_axis_tvalid(h2_valid), .s0_axis_tlast(1'b1),
        .s0_axis_tready(h2_s0_tready),
        .s1_axis_tdata(256'd0), .s1_axis_tkeep(32'd0),
        .s1_axis_tvalid(h2_valid), .s1_axis_tlast(1'b1),
        .s1_axis_tready(h2_s1_tready),
        .m_axis_tdata(h2_tdata), .m_axis_tkeep(h2_tkeep),
        .m_axis_tvalid(h2_tvalid), .m_axis_tlast(h2_tlast),
        .m_axis_tready(1'b1),
        .grant(h2_grant), .busy(h2_busy)
`ifdef ARB_PKT_CNT_EN
        , .pkt_cnt0(h2_cnt0), .pkt_cnt1(h2_cnt1)
`endif
    );

    int           n_checks = 0;
    int           n_errors = 0;
    beat_t        sbq [2][$];
    logic [1:0]   gq [$];
    logic [1:0]   hq [$];
    int           pkts_left [2];
    int           pkt_len [2];
    int           pkt_no [2];
    int           beat_no [2];
    logic         src_vld [2];
    logic [255:0] src_data [2];
    logic [31:0]  src_keep [2];
    logic         src_last [2];
    bit           hs [2];
    bit           gap_en = 1'b0;
    bit           tog_en = 1'b0;
    bit           mon_en = 1'b0;
    bit           tlast_done = 1'b0;
    logic [1:0]   prev_grant = 2'b00;
    logic [1:0]   h2_prev = 2'b00;
    logic [1:0]   exp_g;
    beat_t        mon_b;
    int           mon_p;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_data(input int n, input int p, input int b);
        return {8'(n), 16'(p), 16'(b), 216'(n * 100003 + p * 1009 + b * 7 + 1)};
    endfunction

    task automatic at_neg();
        @(negedge aclk);
        #1;
    endtask

    task automatic apply_src();
        s0_axis_tvalid = src_vld[0];
        s0_axis_tdata  = src_data[0];
        s0_axis_tkeep  = src_keep[0];
        s0_axis_tlast  = src_last[0];
        s1_axis_tvalid = src_vld[1];
        s1_axis_tdata  = src_data[1];
        s1_axis_tkeep  = src_keep[1];
        s1_axis_tlast  = src_last[1];
    endtask

    task automatic clear_src();
        for (int n = 0; n < 2; n++) begin
            src_vld[n]   = 1'b0;
            src_data[n]  = 256'd0;
            src_keep[n]  = 32'd0;
            src_last[n]  = 1'b0;
            pkts_left[n] = 0;
            pkt_no[n]    = 0;
            beat_no[n]   = 0;
            sbq[n].delete();
        end
        gq.delete();
        apply_src();
    endtask

    // Source model: advances on observed handshakes, holds a beat until accepted.
    task automatic drive_step();
        for (int n = 0; n < 2; n++) begin
            if (src_vld[n] && hs[n]) begin
                if (src_last[n]) begin
                    pkts_left[n]--;
                    pkt_no[n]++;
                    beat_no[n] = 0;
                end else begin
                    beat_no[n]++;
                end
                src_vld[n] = 1'b0;
            end
            if (!src_vld[n] && pkts_left[n] > 0) begin
                if (!gap_en || beat_no[n] == 0 || $urandom_range(0, 2) != 0) begin
                    src_vld[n]  = 1'b1;
                    src_data[n] = mk_data(n, pkt_no[n], beat_no[n]);
                    src_keep[n] = {16'(pkt_no[n]), 16'(beat_no[n])} ^ 32'h5A5A_0F0F;
                    src_last[n] = (beat_no[n] == pkt_len[n] - 1);
                    sbq[n].push_back('{d: src_data[n], k: src_keep[n], l: src_last[n]});
                end
            end
        end
        if (tog_en) m_axis_tready = ~m_axis_tready;
        apply_src();
    endtask

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            drive_step();
        end
    end

    // Monitor: sample away from the active edge, pop the scoreboard on master handshakes.
    always @(negedge aclk) begin
        hs[0] = s0_axis_tvalid & s0_axis_tready;
        hs[1] = s1_axis_tvalid & s1_axis_tready;
        if (mon_en && aresetn) begin
            check_val("busy_vs_grant", 256'(busy), 256'(|grant));
            if (grant == 2'b00) check_val("idle_mtvalid", 256'(m_axis_tvalid), 256'd0);
            if (grant == 2'b01) check_val("p1_tready_blocked", 256'(s1_axis_tready), 256'd0);
            if (grant == 2'b10) check_val("p0_tready_blocked", 256'(s0_axis_tready), 256'd0);
            if (prev_grant != 2'b00 && grant != 2'b00)
                check_val("grant_stable", 256'(grant), 256'(prev_grant));
            if (tlast_done) check_val("turnaround_idle", 256'(grant), 256'd0);
            if (prev_grant == 2'b00 && grant != 2'b00 && gq.size() > 0) begin
                exp_g = gq.pop_front();
                check_val("grant_order", 256'(grant), 256'(exp_g));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                mon_p = (grant == 2'b10) ? 1 : 0;
                check_val("hs_owner_valid", 256'(grant == 2'b01 || grant == 2'b10), 256'd1);
                if (sbq[mon_p].size() == 0) begin
                    check_val("unexpected_beat", 256'd1, 256'd0);
                end else begin
                    mon_b = sbq[mon_p].pop_front();
                    check_val("beat_data", m_axis_tdata, mon_b.d);
                    check_val("beat_keep", 256'(m_axis_tkeep), 256'(mon_b.k));
                    check_val("beat_last", 256'(m_axis_tlast), 256'(mon_b.l));
                end
            end
        end
        if (aresetn && h2_prev == 2'b00 && h2_grant != 2'b00 && hq.size() > 0) begin
            exp_g = hq.pop_front();
            check_val("h2_grant_order", 256'(h2_grant), 256'(exp_g));
        end
        tlast_done = m_axis_tvalid & m_axis_tready & m_axis_tlast & aresetn;
        prev_grant = grant;
        h2_prev    = h2_grant;
    end

    task automatic do_reset();
        at_neg();
        aresetn = 1'b0;
        clear_src();
        at_neg();
        at_neg();
        check_val("rst_grant", 256'(grant), 256'd0);
        check_val("rst_busy", 256'(busy), 256'd0);
        check_val("rst_mtvalid", 256'(m_axis_tvalid), 256'd0);
        check_val("rst_tready", 256'({s0_axis_tready, s1_axis_tready}), 256'd0);
`ifdef ARB_PKT_CNT_EN
        check_val("rst_pkt_cnt", 256'({pkt_cnt0, pkt_cnt1}), 256'd0);
`endif
        aresetn = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while ((pkts_left[0] > 0 || pkts_left[1] > 0 || src_vld[0] || src_vld[1] ||
                grant != 2'b00) && i < budget) begin
            at_neg();
            i++;
        end
        if (i >= budget) check_val("timeout", 256'd0, 256'd1);
    endtask

    initial begin
        int t_v, t_g, t_l;
        aresetn       = 1'b0;
        m_axis_tready = 1'b1;
        h2_valid      = 1'b0;
        clear_src();
        do_reset();
        mon_en = 1'b1;

        // HOLD_MAX=2 instance with back-to-back single-beat packets on both ports
        hq = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
        h2_valid = 1'b1;
        repeat (20) at_neg();
        h2_valid = 1'b0;
        check_val("h2_order_done", 256'(hq.size()), 256'd0);

        // Single 48-beat packet on port 0
        do_reset();
        t_v = -1; t_g = -1; t_l = -1;
        pkt_len[0] = 48;
        pkts_left[0] = 1;
        for (int i = 0; i < 200 && t_l < 0; i++) begin
            at_neg();
            if (t_v < 0 && s0_axis_tvalid) t_v = i;
            if (t_g < 0 && grant == 2'b01) t_g = i;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) t_l = i;
        end
        check_val("first_grant_latency", 256'(t_g - t_v), 256'd1);
        check_val("pkt48_cycles", 256'(t_l - t_g + 1), 256'd48);
        at_neg();
        check_val("idle_after_pkt48", 256'(grant), 256'd0);
        wait_done(100);

        // Continuous contention, HOLD_MAX=1 -> strict alternation
        do_reset();
        gq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        pkt_len[0] = 3; pkt_len[1] = 5;
        pkts_left[0] = 4; pkts_left[1] = 4;
        wait_done(2000);
        check_val("alt_order_done", 256'(gq.size()), 256'd0);
`ifdef ARB_PKT_CNT_EN
        check_val("pkt_cnt0_4", 256'(pkt_cnt0), 256'd4);
        check_val("pkt_cnt1_4", 256'(pkt_cnt1), 256'd4);
`endif

        // Port-1 packet with toggling tready and source gaps while port 0 waits
        do_reset();
        gap_en = 1'b1;
        tog_en = 1'b1;
        gq = '{2'b10, 2'b01};
        pkt_len[1] = 9;
        pkts_left[1] = 1;
        at_neg();
        pkt_len[0] = 4;
        pkts_left[0] = 1;
        wait_done(2000);
        tog_en = 1'b0;
        gap_en = 1'b0;
        m_axis_tready = 1'b1;
        check_val("stall_order_done", 256'(gq.size()), 256'd0);

        // Reset in the middle of a port-0 packet, then contention goes to port 0
        do_reset();
        pkt_len[0] = 20;
        pkts_left[0] = 1;
        for (int i = 0; i < 100 && beat_no[0] < 10; i++) at_neg();
        check_val("abort_reached_beat10", 256'(beat_no[0]), 256'd10);
        aresetn = 1'b0;
        at_neg();
        check_val("abort_grant", 256'(grant), 256'd0);
        check_val("abort_busy", 256'(busy), 256'd0);
        check_val("abort_mtvalid", 256'(m_axis_tvalid), 256'd0);
        check_val("abort_p0_tready", 256'(s0_axis_tready), 256'd0);
        clear_src();
        aresetn = 1'b1;
        gq = '{2'b01, 2'b10};
        pkt_len[0] = 2; pkt_len[1] = 2;
        pkts_left[0] = 1; pkts_left[1] = 1;
        wait_done(200);
        check_val("post_abort_order_done", 256'(gq.size()), 256'd0);

`ifdef ARB_PKT_CNT_EN
        // Counter wrap via backdoor preload
        force dut.pkt_cnt1_r = 32'hFFFF_FFFF;
        at_neg();
        release dut.pkt_cnt1_r;
        check_val("cnt1_preload", 256'(pkt_cnt1), 256'hFFFF_FFFF);
        pkt_len[1] = 3;
        pkts_left[1] = 1;
        wait_done(200);
        check_val("cnt1_wrap", 256'(pkt_cnt1), 256'd0);
`endif

        at_neg();
        check_val("sb0_drained", 256'(sbq[0].size()), 256'd0);
        check_val("sb1_drained", 256'(sbq[1].size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
